// File: rtl/reg_bank_if.sv
// Register bank port bundle: decode-side reads/issue and writeback-side write.
// The master drives addresses and strobes, the slave (reg_bank) returns data and scoreboard.
interface reg_bank_if #(
    parameter int SIZE   = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]    rd_addr_a;
    logic [ADDR_W-1:0]    rd_addr_b;
    logic [SIZE-1:0]      rd_data_a;
    logic [SIZE-1:0]      rd_data_b;
    logic                 rd_en_a;
    logic                 rd_en_b;
    logic                 stall;
    logic                 iss_en;
    logic [ADDR_W-1:0]    iss_addr;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [SIZE-1:0]      wr_data;
    logic [2**ADDR_W-1:0] pend;

    modport master (
        output rd_addr_a, rd_addr_b, rd_en_a, rd_en_b,
        output iss_en, iss_addr, wr_en, wr_addr, wr_data,
        input  rd_data_a, rd_data_b, stall, pend
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, rd_en_a, rd_en_b,
        input  iss_en, iss_addr, wr_en, wr_addr, wr_data,
        output rd_data_a, rd_data_b, stall, pend
    );
endinterface

// File: rtl/reg_bank.sv
// Register bank with two combinational read ports, one write port and a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding when REG_BANK_BYPASS_EN is defined.
module reg_bank #(
    parameter int SIZE   = 32,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_bank_if.slave  bus
);
    localparam int N = 2**ADDR_W;

    logic [N-1:0][SIZE-1:0] mem_q, mem_d;
    logic [N-1:0]           pend_q, pend_d;
    logic                   stall_a, stall_b;

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (bus.wr_en) begin
            mem_d[bus.wr_addr]  = bus.wr_data;
            pend_d[bus.wr_addr] = 1'b0;
        end
        // issue applied last so a same-address issue outlives the retire
        if (bus.iss_en) begin
            pend_d[bus.iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

`ifdef REG_BANK_BYPASS_EN
    logic hit_a, hit_b, remark_a, remark_b;

    always_comb begin
        hit_a    = bus.wr_en && (bus.wr_addr == bus.rd_addr_a);
        hit_b    = bus.wr_en && (bus.wr_addr == bus.rd_addr_b);
        remark_a = bus.iss_en && (bus.iss_addr == bus.rd_addr_a);
        remark_b = bus.iss_en && (bus.iss_addr == bus.rd_addr_b);
        bus.rd_data_a = hit_a ? bus.wr_data : mem_q[bus.rd_addr_a];
        bus.rd_data_b = hit_b ? bus.wr_data : mem_q[bus.rd_addr_b];
        stall_a = bus.rd_en_a && pend_q[bus.rd_addr_a]
                  && !(hit_a && !remark_a);
        stall_b = bus.rd_en_b && pend_q[bus.rd_addr_b]
                  && !(hit_b && !remark_b);
    end
`else
    always_comb begin
        bus.rd_data_a = mem_q[bus.rd_addr_a];
        bus.rd_data_b = mem_q[bus.rd_addr_b];
        stall_a = bus.rd_en_a && pend_q[bus.rd_addr_a];
        stall_b = bus.rd_en_b && pend_q[bus.rd_addr_b];
    end
`endif

    assign bus.stall = stall_a || stall_b;
    assign bus.pend  = pend_q;
endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// checked every cycle against an array-based model of the register file.
module tb_reg_bank;
    localparam int SIZE   = 32;
    localparam int ADDR_W = 4;
    localparam int N      = 16;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    reg_bank_if #(.SIZE(SIZE), .ADDR_W(ADDR_W)) bus ();

    reg_bank #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference state
    logic [31:0] m_mem [N];
    bit          m_pend [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_mem[i]  = 32'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (bus.wr_en) begin
                m_mem[bus.wr_addr] = bus.wr_data;
                if (!(bus.iss_en && bus.iss_addr == bus.wr_addr))
                    m_pend[bus.wr_addr] = 1'b0;
            end
            if (bus.iss_en)
                m_pend[bus.iss_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(logic [3:0] a);
        if (BYP && bus.wr_en && bus.wr_addr == a)
            return bus.wr_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_port_stall(bit en, logic [3:0] a);
        bit retiring;
        retiring = BYP && bus.wr_en && bus.wr_addr == a
                   && !(bus.iss_en && bus.iss_addr == a);
        return en && m_pend[a] && !retiring;
    endfunction

    function automatic logic [15:0] exp_pend();
        logic [15:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        check("rd_data_a", bus.rd_data_a, exp_rd(bus.rd_addr_a));
        check("rd_data_b", bus.rd_data_b, exp_rd(bus.rd_addr_b));
        check("stall", {31'b0, bus.stall},
              {31'b0, exp_port_stall(bus.rd_en_a, bus.rd_addr_a)
                    | exp_port_stall(bus.rd_en_b, bus.rd_addr_b)});
        check("pend", {16'b0, bus.pend}, {16'b0, exp_pend()});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en_a = 0; bus.rd_en_b = 0;
        bus.iss_en  = 0; bus.wr_en   = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rd_addr_a = 0; bus.rd_addr_b = 0;
        bus.iss_addr  = 0; bus.wr_addr   = 0;
        bus.wr_data   = 0;
        idle();
        #1;
        check("reset rd_data_a", bus.rd_data_a, 32'h0);
        check("reset pend", {16'b0, bus.pend}, 32'h0);
        check("reset stall", {31'b0, bus.stall}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // write then read next cycle on both ports
        bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 32'hDEADBEEF;
        step();
        idle();
        bus.rd_addr_a = 3; bus.rd_addr_b = 3;
        #1;
        check("wr3 port a", bus.rd_data_a, 32'hDEADBEEF);
        check("wr3 port b", bus.rd_data_b, 32'hDEADBEEF);

        // issue 5, stall, retire 5
        bus.iss_en = 1; bus.iss_addr = 5;
        step();
        idle();
        check("pend5 set", {31'b0, bus.pend[5]}, 32'h1);
        bus.rd_en_a = 1; bus.rd_addr_a = 5;
        #1;
        check("stall on 5", {31'b0, bus.stall}, 32'h1);
        bus.rd_en_a = 0;
        bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 32'h00000055;
        step();
        idle();
        bus.rd_en_a = 1;
        #1;
        check("pend5 clear", {31'b0, bus.pend[5]}, 32'h0);
        check("stall clear", {31'b0, bus.stall}, 32'h0);
        check("rd5 data", bus.rd_data_a, 32'h00000055);
        bus.rd_en_a = 0;

        // issue and retire together
        bus.iss_en = 1; bus.iss_addr = 7;
        step();
        check("pend7 set", {31'b0, bus.pend[7]}, 32'h1);
        bus.wr_en = 1; bus.wr_addr = 7;
        step();
        check("pend7 kept", {31'b0, bus.pend[7]}, 32'h1);
        bus.iss_addr = 2;
        step();
        idle();
        check("pend2 set", {31'b0, bus.pend[2]}, 32'h1);
        check("pend7 clr", {31'b0, bus.pend[7]}, 32'h0);

        // rd_en qualifies the stall
        bus.iss_en = 1; bus.iss_addr = 5;
        step();
        idle();
        bus.rd_addr_a = 5; bus.rd_addr_b = 0;
        #1;
        check("stall ungated", {31'b0, bus.stall}, 32'h0);
        bus.rd_en_b = 1; bus.rd_addr_b = 5;
        #1;
        check("stall port b", {31'b0, bus.stall}, 32'h1);
        bus.rd_en_b = 0;

        // same-cycle write to the entry being read
        bus.iss_en = 1; bus.iss_addr = 9;
        bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'hAAAA0000;
        step();
        idle();
        bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'h12345678;
        bus.rd_en_a = 1; bus.rd_addr_a = 9;
        #1;
        if (BYP) begin
            check("bypass data", bus.rd_data_a, 32'h12345678);
            check("bypass stall", {31'b0, bus.stall}, 32'h0);
        end else begin
            check("nobyp data", bus.rd_data_a, 32'hAAAA0000);
            check("nobyp stall", {31'b0, bus.stall}, 32'h1);
        end
        step();
        bus.wr_en = 0;
        #1;
        check("wr9 data", bus.rd_data_a, 32'h12345678);
        check("pend9 clr", {31'b0, bus.pend[9]}, 32'h0);

        // asynchronous reset mid-cycle
        bus.iss_en = 1; bus.iss_addr = 9;
        step();
        idle();
        bus.rd_en_a = 1;
        #1;
        rst_n = 1'b0;
        #1;
        check("async rd_data_a", bus.rd_data_a, 32'h0);
        check("async pend", {16'b0, bus.pend}, 32'h0);
        check("async stall", {31'b0, bus.stall}, 32'h0);
        step();
        bus.wr_en = 1; bus.wr_addr = 4; bus.wr_data = 32'hCAFEF00D;
        rst_n = 1'b1;
        step();
        idle();
        bus.rd_addr_b = 4;
        #1;
        check("post-reset write", bus.rd_data_b, 32'hCAFEF00D);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bus.rd_addr_a = 4'($urandom);
            bus.rd_addr_b = 4'($urandom);
            bus.rd_en_a   = 1'($urandom);
            bus.rd_en_b   = 1'($urandom);
            bus.iss_en    = ($urandom_range(0, 2) == 0);
            bus.iss_addr  = 4'($urandom_range(0, 7));
            bus.wr_en     = ($urandom_range(0, 2) == 0);
            bus.wr_addr   = 4'($urandom_range(0, 7));
            bus.wr_data   = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
